// File: rtl/jt49_div_mc.sv
// Multi-channel programmable divider: CH period/counter pairs driving toggle or pulse outputs plus a wrap tick.
// Outputs are registered and change on the wrapping cen edge (0 extra latency). There is no backpressure.
module jt49_div_mc #(
  parameter int W       = 12,
  parameter int CH      = 3,
  parameter int AW      = 2,
  parameter int RESTART = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          sync,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] mode,
  input  logic          wr,
  input  logic [AW-1:0] wr_ch,
  input  logic [W-1:0]  wr_data,
  output logic [CH-1:0] div,
  output logic [CH-1:0] tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]  period_q [CH];
  logic [W-1:0]  period_d [CH];
  logic [W-1:0]  count_q  [CH];
  logic [W-1:0]  count_d  [CH];
  logic [W-1:0]  eff      [CH];
  logic [CH-1:0] div_q, div_d;
  logic [CH-1:0] tick_q, tick_d;

  // A zero period behaves as one so the counter never runs out to 2^W.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      eff[i] = (period_q[i] == '0) ? ONE : period_q[i];
    end
  end

  always_comb begin
    div_d  = div_q;
    tick_d = '0;
    for (int i = 0; i < CH; i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      if (sync) begin
        count_d[i] = ONE;
        div_d[i]   = 1'b0;
      end else if (cen && en[i]) begin
        if (count_q[i] >= eff[i]) begin
          count_d[i] = ONE;
          tick_d[i]  = 1'b1;
          div_d[i]   = mode[i] ? 1'b1 : ~div_q[i];
        end else begin
          count_d[i] = count_q[i] + ONE;
          div_d[i]   = mode[i] ? 1'b0 : div_q[i];
        end
      end
      // Indices at or beyond CH never match, so out-of-range writes are dropped.
      if (wr && (wr_ch == AW'(i))) begin
        period_d[i] = wr_data;
        if (RESTART != 0) begin
          count_d[i] = ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= ONE;
      end
      div_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign div  = div_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_jt49_div_mc.sv
// Directed bench for jt49_div_mc; a second instance built with RESTART=0 covers the no-restart write path.
module tb_jt49_div_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        sync;
  logic [2:0]  en;
  logic [2:0]  mode;
  logic        wr;
  logic [1:0]  wr_ch;
  logic [11:0] wr_data;
  logic [2:0]  div_a, tick_a, div_b, tick_b;

  int checks = 0;
  int errors = 0;

  jt49_div_mc #(.W(12), .CH(3), .AW(2), .RESTART(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync), .en(en), .mode(mode),
    .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data), .div(div_a), .tick(tick_a)
  );

  jt49_div_mc #(.W(12), .CH(3), .AW(2), .RESTART(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync), .en(en), .mode(mode),
    .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data), .div(div_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  // Inputs are set at a negedge; outputs are read at the following negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_period(input logic [1:0] ch, input logic [11:0] val);
    wr = 1'b1; wr_ch = ch; wr_data = val; cen = 1'b0;
    cyc();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b0; sync = 1'b0; en = '0; mode = '0;
    wr = 1'b0; wr_ch = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (div_a !== 3'b000 || tick_a !== 3'b000) begin
      errors++;
      $display("FAIL reset: div=%b tick=%b required div=000 tick=000", div_a, tick_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_toggle();
    logic ed, et;
    en = 3'b001; mode = 3'b000;
    write_period(2'd0, 12'd3);
    cen = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      et = (k % 3 == 0);
      ed = ((k / 3) % 2) == 1;
      checks++;
      if (tick_a[0] !== et || div_a[0] !== ed) begin
        errors++;
        $display("FAIL toggle k=%0d: div0=%b tick0=%b required div0=%b tick0=%b", k, div_a[0], tick_a[0], ed, et);
      end
    end
  endtask

  task automatic test_period_zero_one();
    logic ed, et;
    int   n;
    en = 3'b110; mode = 3'b000;
    write_period(2'd1, 12'd0);
    write_period(2'd2, 12'd1);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      cen = (k % 2 == 1);
      cyc();
      if (k % 2 == 1) n++;
      et = (k % 2 == 1);
      ed = (n % 2 == 1);
      checks++;
      if (div_a[2:1] !== {ed, ed} || tick_a[2:1] !== {et, et}) begin
        errors++;
        $display("FAIL period01 k=%0d: div[2:1]=%b tick[2:1]=%b required div=%b%b tick=%b%b",
                 k, div_a[2:1], tick_a[2:1], ed, ed, et, et);
      end
    end
  endtask

  task automatic test_period_lower();
    logic eta, etb, eda, edb;
    en = 3'b001; mode = 3'b000;
    write_period(2'd0, 12'd10);
    cen = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (tick_a[0] !== 1'b0 || tick_b[0] !== 1'b0) begin
        errors++;
        $display("FAIL lower_pre k=%0d: tick0 r1=%b r0=%b required 0", k, tick_a[0], tick_b[0]);
      end
    end
    eda = div_a[0]; edb = div_b[0];
    // The lower period is written on a cen edge while the count sits at 7.
    wr = 1'b1; wr_ch = 2'd0; wr_data = 12'd4;
    for (int k = 0; k <= 12; k++) begin
      cyc();
      wr = 1'b0;
      eta = (k != 0) && (k % 4 == 0);
      etb = (k % 4 == 1);
      if (eta) eda = ~eda;
      if (etb) edb = ~edb;
      checks++;
      if (tick_a[0] !== eta || div_a[0] !== eda) begin
        errors++;
        $display("FAIL lower_restart k=%0d: div0=%b tick0=%b required div0=%b tick0=%b", k, div_a[0], tick_a[0], eda, eta);
      end
      checks++;
      if (tick_b[0] !== etb || div_b[0] !== edb) begin
        errors++;
        $display("FAIL lower_norestart k=%0d: div0=%b tick0=%b required div0=%b tick0=%b", k, div_b[0], tick_b[0], edb, etb);
      end
    end
  endtask

  task automatic test_pulse_mode();
    logic ed, et;
    en = 3'b010; mode = 3'b010;
    write_period(2'd1, 12'd5);
    cen = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) mode = 3'b000;
      cyc();
      et = (k % 5 == 0);
      if (k <= 10) ed = et;
      else         ed = (k < 15) || (k >= 20);
      checks++;
      if (tick_a[1] !== et || div_a[1] !== ed) begin
        errors++;
        $display("FAIL pulse k=%0d: div1=%b tick1=%b required div1=%b tick1=%b", k, div_a[1], tick_a[1], ed, et);
      end
    end
  endtask

  task automatic test_sync();
    logic [2:0] et, ed;
    en = 3'b111; mode = 3'b000; cen = 1'b1;
    repeat (2) cyc();
    sync = 1'b1; wr = 1'b1; wr_ch = 2'd2; wr_data = 12'd3;
    cyc();
    sync = 1'b0; wr = 1'b0;
    checks++;
    if (div_a !== 3'b000 || tick_a !== 3'b000) begin
      errors++;
      $display("FAIL sync: div=%b tick=%b required div=000 tick=000", div_a, tick_a);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      et = {(k % 3 == 0), (k == 5), (k == 4)};
      ed = {(k >= 3 && k <= 5), (k >= 5), (k >= 4)};
      checks++;
      if (tick_a !== et || div_a !== ed) begin
        errors++;
        $display("FAIL post_sync k=%0d: div=%b tick=%b required div=%b tick=%b", k, div_a, tick_a, ed, et);
      end
    end
  endtask

  task automatic test_freeze_and_range();
    logic [2:0] et;
    en = 3'b000; cen = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) begin
        wr = 1'b1; wr_ch = 2'd3; wr_data = 12'd2;
      end
      cyc();
      wr = 1'b0;
      checks++;
      if (tick_a !== 3'b000 || div_a !== 3'b011) begin
        errors++;
        $display("FAIL freeze k=%0d: div=%b tick=%b required div=011 tick=000", k, div_a, tick_a);
      end
    end
    en = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      et = {(k % 3 == 0), (k == 4 || k == 9), (k == 2 || k == 6 || k == 10)};
      checks++;
      if (tick_a !== et) begin
        errors++;
        $display("FAIL resume k=%0d: tick=%b required %b", k, tick_a, et);
      end
    end
    checks++;
    if (div_a !== 3'b110) begin
      errors++;
      $display("FAIL resume_div: div=%b required 110", div_a);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (div_a !== 3'b000 || tick_a !== 3'b000 || div_b !== 3'b000 || tick_b !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: div=%b tick=%b div_r0=%b tick_r0=%b required all 000", div_a, tick_a, div_b, tick_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_period_zero_one();
    test_period_lower();
    test_pulse_mode();
    test_sync();
    test_freeze_and_range();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_div_mc.md
Name: jt49_div_mc

Overview:
- Multi-channel programmable clock divider: the next-generation tone/noise divider for the PSG core.
- Holds CH independent period registers and counters, each loaded through a shared write port.
- Each channel output is either a 50% square (toggle mode) or a one-cen-period strobe (pulse mode), plus a one-clk wrap tick.
- Sits between the register file and the tone/noise/envelope generators; counters advance on the shared clock enable.

Parameters:
- W, 12, period/counter width in bits (W >= 2).
- CH, 3, number of channels (1..16).
- AW, 2, width of the channel-select field; must satisfy 2^AW >= CH.
- RESTART, 1, when 1 a period write also restarts that channel's counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cen  in  1  clock enable; counters advance only on clk edges with cen=1.
- sync  in  1  synchronous phase reset of all channels; cen not required.
- en  in  CH  per-channel run enable.
- mode  in  CH  per-channel output mode: 0 = toggle, 1 = pulse.
- wr  in  1  period write strobe, one clk.
- wr_ch  in  AW  channel index for the write.
- wr_data  in  W  new period value.
- div  out  CH  divided outputs, registered.
- tick  out  CH  wrap strobe, registered, one clk wide.

Behaviour:
Reset (async, rst_n=0):
- period[i] = 0, count[i] = 1, div = 0, tick = 0.

Effective period:
- eff[i] = (period[i] == 0) ? 1 : period[i].
- Period 0 behaves exactly as period 1: wrap on every cen.

Per channel i, per clk edge, in priority order:
1. sync=1: count[i] <= 1, div[i] <= 0, tick[i] <= 0. Pending writes still update period[i].
2. cen=1 and en[i]=1, wrap case (count[i] >= eff[i], using the period value before any same-edge write):
   - count[i] <= 1, tick[i] <= 1.
   - mode=0: div[i] <= ~div[i].
   - mode=1: div[i] <= 1.
3. cen=1 and en[i]=1, no wrap: count[i] <= count[i] + 1, tick[i] <= 0.
   - mode=1: div[i] <= 0.
   - mode=0: div[i] holds.
4. Otherwise (cen=0 or en[i]=0): count and div hold; tick[i] <= 0.

Wrap timing and arithmetic:
- A channel with period P wraps once every P cen pulses.
- Toggle mode: div period = 2P cen pulses.
- Pulse mode: div is high for exactly one cen interval (wrap edge to next cen edge).
- Counter arithmetic is unsigned W-bit. The compare is >=, so lowering the period below the current count forces a wrap on the next cen, with no run-out to 2^W.

Write port:
- wr=1 with wr_ch < CH: period[wr_ch] <= wr_data at that edge; used by compares from the next edge.
- wr_ch >= CH: write ignored, no state change.
- RESTART=1: the write also forces count[wr_ch] <= 1, overriding any same-edge increment or wrap reload. div and tick still take their cen-driven values.
- RESTART=0: the count is untouched.

Mode changes:
- mode[i] changing mid-run takes effect at the next cen; div is not reset.
- Switching pulse -> toggle leaves div at its current level.

en deassert:
- Freezes count and div; tick stays low.
- Re-assert resumes from the held count.

Latency:
- div and tick change on the same edge as the wrapping cen; no extra pipeline stage.

Test Plan:
1. Reset, write ch0 period=3, cen held high, mode=0, en=1 -> div[0] toggles every 3 clk (period 6); tick[0] high 1 clk every 3 clk; first tick on the 3rd cen after write.
2. Period 0 and period 1 on ch1/ch2, cen every 2nd clk -> both div toggle on every cen, identical waveforms, tick each cen.
3. ch0 period=10 running at count=7, write period=4 (RESTART=0) -> wrap on next cen, count=1, div toggles; afterwards every 4 cen. Repeat with RESTART=1 -> count=1 at the write edge, no wrap, next wrap after 4 cen.
4. mode[1]=1, period=5, cen every clk -> div[1] high exactly 1 clk in every 5; switch mode to 0 mid-run -> toggling resumes from the current level at the next wrap.
5. sync pulse while all channels are mid-count, with cen=1 on the same edge -> all count=1, div=0, tick=0; the same-edge write to ch2 still lands in period[2].
6. en[0]=0 for 20 cen, wr_ch=3 with CH=3 -> ch0 frozen then resumes from the held count; the out-of-range write changes no period; async rst_n low mid-run -> all outputs 0 immediately.
